serdes_sync_rx: RTL
===================

Name: serdes_sync_rx

Overview:
- Receive-side partner of the serdes link's sync transmitter. It sits downstream of the RX byte-aligner.
- It searches the aligned 16-bit word stream for the 3-word sync sequence 0xbaf1, 0xff84, 0x69aa, which encodes the 48-bit pattern f1ba_84ff_aa69.
- On a match it emits a one-cycle sync pulse, strips the three sync words from the payload stream, and maintains a lock/timeout status.
- All logic runs in the recovered RX clock domain.

Parameters:
P_SYNC_W0, 16'hbaf1, first sync word expected on the link
P_SYNC_W1, 16'hff84, second sync word
P_SYNC_W2, 16'h69aa, third sync word
P_TIMEOUT, 20'hfffff, RX cycles without a sync before lock is dropped; 0 = never drop
P_SEQ_W, 8, width of the sync event counter

Ports:
I_serdes_rx_clk  input  1  recovered RX clock
I_rst_n  input  1  async reset, active-low
I_user_data  input  16  aligned word from the RX byte-aligner
I_data_ena  input  1  I_user_data is a valid non-comma word
O_user_data  output  16  payload word, delayed, with sync words stripped
O_data_ena  output  1  O_user_data valid
O_sync_pulse  output  1  one-cycle pulse per detected sync sequence
O_locked  output  1  a sync was seen within the last P_TIMEOUT cycles
O_sync_seq  output  P_SEQ_W  count of detected syncs, wraps
O_lock_lost  output  1  one-cycle pulse when O_locked falls because of the timeout

Behaviour:
- Reset: I_rst_n is asynchronous, active-low; the clock is I_serdes_rx_clk. All outputs reset to 0. The 3-stage pipeline, timeout counter and sequence counter also reset to 0.
- Pipeline: 3 stages, S0 newest to S2 oldest, each holding {data, vld}.
  - Every edge: S0 <= {I_user_data, I_data_ena}, S1 <= S0, S2 <= S1.
  - The stream never stalls.
- Match: combinational and registered on the next edge.
  - Condition: S2 = {P_SYNC_W0, 1}, S1 = {P_SYNC_W1, 1} and S0 = {P_SYNC_W2, 1}.
  - The three words must be valid on consecutive cycles. A vld=0 word anywhere inside the sequence breaks the match.
- Output register, every edge:
  - O_user_data <= S2.data.
  - O_data_ena <= S2.vld & ~match.
- On match, the vld bits of S1 and S0 are cleared as they shift into S2 and S1. All three sync words therefore leave with O_data_ena=0.
- A cleared S0 vld cannot pair with the word entering that cycle. Back-to-back overlapping sequences therefore cannot double-count.
- Latency: input to O_user_data is 4 edges. O_sync_pulse rises on the same edge that O_data_ena=0 is output for the first sync word (P_SYNC_W0).
- O_sync_pulse <= match. O_sync_seq increments on match and wraps from all-ones to 0.
- Timeout counter, 20 bits:
  - Cleared on match.
  - Otherwise, while O_locked=1, it increments, saturating at P_TIMEOUT.
- Lock:
  - O_locked <= 1 on match.
  - When O_locked=1, P_TIMEOUT!=0 and the counter equals P_TIMEOUT-1, the next edge sets O_locked=0 and O_lock_lost=1 for one cycle.
  - If a match occurs on that same edge, the match wins: O_locked stays 1, no lock_lost pulse, counter cleared.
- Partial sequence: for example W0, W1 then a non-sync word. No pulse, and all three words pass through with their original vld.
- Reset mid-sequence: all pipeline contents are discarded and no pulse is issued.

Optional Feature:
- Macro SERDES_SYNC_SWAP_EN.
- Defined:
  - The matcher additionally accepts the byte-swapped sequence {W0[7:0],W0[15:8]}, {W1 swapped}, {W2 swapped}, with identical strip, pulse and lock behaviour.
  - An extra output O_sync_swapped (1 bit, reset 0) registers 1 on a swapped match and 0 on a normal match. It holds its value between matches.
- Undefined: only the straight sequence matches, and the O_sync_swapped port does not exist.

Decomposition:
- Shared package serdes_link_pkg contains:
  - SYNC_W0/W1/W2 constants (16'hbaf1, 16'hff84, 16'h69aa).
  - K_COMMA constant 8'hbc and IDLE_WORD constant 16'hc5bc.
  - A typedef for the {data[15:0], vld} pipeline entry.
- One sub-module is natural: serdes_sync_match. It is the combinational 3-word comparator, parameterised on the words, instantiated once, or twice with SERDES_SYNC_SWAP_EN.
- The pipeline, counters and lock logic stay in the top module.

Test Plan:
- Sequence of valid words 0x1111, 0xbaf1, 0xff84, 0x69aa, 0x2222 with ena=1 -> O_data_ena=1 with 0x1111 at edge 4, then three cycles of O_data_ena=0 with the first carrying O_sync_pulse=1, then 0x2222 valid. O_sync_seq=1, O_locked=1.
- Sync words with one ena=0 cycle between 0xff84 and 0x69aa -> no pulse. 0xbaf1, 0xff84 and 0x69aa all output with O_data_ena=1, O_locked stays 0.
- P_TIMEOUT=8: send a sync, then idle -> O_locked falls exactly 8 cycles after the pulse edge, O_lock_lost pulses once. A sync on the 8th cycle -> O_locked stays 1 and no pulse.
- 256 back-to-back sync sequences with P_SEQ_W=8 -> 256 pulses, O_sync_seq wraps to 0, and no payload words are output.
- Assert I_rst_n=0 after W0 and W1, release, send W2 -> no pulse, all outputs 0 during reset.
- With SERDES_SYNC_SWAP_EN: send 0xf1ba, 0x84ff, 0xaa69 -> pulse with O_sync_swapped=1. A following straight sequence -> O_sync_swapped=0.

Source files
------------

// File: rtl/serdes_link_pkg.sv
// Shared serdes link constants and the RX sync pipeline entry type.
package serdes_link_pkg;

  localparam logic [15:0] SYNC_W0   = 16'hbaf1;
  localparam logic [15:0] SYNC_W1   = 16'hff84;
  localparam logic [15:0] SYNC_W2   = 16'h69aa;
  localparam logic [7:0]  K_COMMA   = 8'hbc;
  localparam logic [15:0] IDLE_WORD = 16'hc5bc;
  localparam int          TMO_W     = 20;

  typedef struct packed {
    logic [15:0] data;
    logic        vld;
  } sync_pipe_t;

  function automatic logic [15:0] byte_swap(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/serdes_sync_match.sv
// Combinational 3-word sync comparator over the S2 (oldest) .. S0 (newest) pipeline stages.
module serdes_sync_match
  import serdes_link_pkg::*;
#(
  parameter logic [15:0] P_W0 = SYNC_W0,
  parameter logic [15:0] P_W1 = SYNC_W1,
  parameter logic [15:0] P_W2 = SYNC_W2
) (
  input  sync_pipe_t s2_i,
  input  sync_pipe_t s1_i,
  input  sync_pipe_t s0_i,
  output logic       match_o
);

  // Every word must be valid: an invalid cycle inside the sequence breaks it.
  assign match_o = s2_i.vld && s1_i.vld && s0_i.vld &&
                   (s2_i.data == P_W0) && (s1_i.data == P_W1) && (s0_i.data == P_W2);

endmodule

// File: rtl/serdes_sync_rx.sv
// RX sync detector: strips the 3-word sync sequence, pulses per sync, counts syncs, tracks lock.
// Define SERDES_SYNC_SWAP_EN to also accept the byte-swapped sequence (adds O_sync_swapped).
module serdes_sync_rx
  import serdes_link_pkg::*;
#(
  parameter logic [15:0]      P_SYNC_W0 = SYNC_W0,
  parameter logic [15:0]      P_SYNC_W1 = SYNC_W1,
  parameter logic [15:0]      P_SYNC_W2 = SYNC_W2,
  parameter logic [TMO_W-1:0] P_TIMEOUT = 20'hfffff,
  parameter int               P_SEQ_W   = 8
) (
  input  logic               I_serdes_rx_clk,
  input  logic               I_rst_n,
  input  logic [15:0]        I_user_data,
  input  logic               I_data_ena,
  output logic [15:0]        O_user_data,
  output logic               O_data_ena,
  output logic               O_sync_pulse,
  output logic               O_locked,
  output logic [P_SEQ_W-1:0] O_sync_seq,
  output logic               O_lock_lost
`ifdef SERDES_SYNC_SWAP_EN
  ,
  output logic               O_sync_swapped
`endif
);

  localparam logic [TMO_W-1:0] TMO_LAST = P_TIMEOUT - TMO_W'(1);
  localparam bit               TMO_EN   = (P_TIMEOUT != '0);

  sync_pipe_t [2:0]   pipe_q, pipe_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [15:0]        data_q;
  logic               ena_q, pulse_q, locked_q, lost_q;
  logic [P_SEQ_W-1:0] seq_q;
  logic               match_str, match_swp, match, tmo_hit;

  serdes_sync_match #(
    .P_W0(P_SYNC_W0), .P_W1(P_SYNC_W1), .P_W2(P_SYNC_W2)
  ) u_match_str (
    .s2_i(pipe_q[2]), .s1_i(pipe_q[1]), .s0_i(pipe_q[0]), .match_o(match_str)
  );

`ifdef SERDES_SYNC_SWAP_EN
  logic swp_q;

  serdes_sync_match #(
    .P_W0(byte_swap(P_SYNC_W0)), .P_W1(byte_swap(P_SYNC_W1)), .P_W2(byte_swap(P_SYNC_W2))
  ) u_match_swp (
    .s2_i(pipe_q[2]), .s1_i(pipe_q[1]), .s0_i(pipe_q[0]), .match_o(match_swp)
  );

  assign O_sync_swapped = swp_q;
`else
  assign match_swp = 1'b0;
`endif

  assign match = match_str | match_swp;

  // Clearing vld on the words behind a match strips them and stops overlapping re-matches.
  always_comb begin
    pipe_d[0].data = I_user_data;
    pipe_d[0].vld  = I_data_ena;
    pipe_d[1].data = pipe_q[0].data;
    pipe_d[1].vld  = pipe_q[0].vld & ~match;
    pipe_d[2].data = pipe_q[1].data;
    pipe_d[2].vld  = pipe_q[1].vld & ~match;
  end

  assign tmo_hit = TMO_EN && locked_q && (tmo_q == TMO_LAST);

  always_comb begin
    tmo_d = tmo_q;
    if (match)
      tmo_d = '0;
    else if (locked_q && (tmo_q != P_TIMEOUT))
      tmo_d = tmo_q + TMO_W'(1);
  end

  always_ff @(posedge I_serdes_rx_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      pipe_q   <= '0;
      tmo_q    <= '0;
      data_q   <= '0;
      ena_q    <= 1'b0;
      pulse_q  <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
      seq_q    <= '0;
    end else begin
      pipe_q  <= pipe_d;
      tmo_q   <= tmo_d;
      data_q  <= pipe_q[2].data;
      ena_q   <= pipe_q[2].vld & ~match;
      pulse_q <= match;
      // A sync arriving on the timeout edge keeps the lock.
      lost_q  <= tmo_hit & ~match;
      if (match) begin
        locked_q <= 1'b1;
        seq_q    <= seq_q + P_SEQ_W'(1);
      end else if (tmo_hit) begin
        locked_q <= 1'b0;
      end
    end
  end

`ifdef SERDES_SYNC_SWAP_EN
  always_ff @(posedge I_serdes_rx_clk or negedge I_rst_n) begin
    if (!I_rst_n)
      swp_q <= 1'b0;
    else if (match)
      swp_q <= match_swp & ~match_str;
  end
`endif

  assign O_user_data  = data_q;
  assign O_data_ena   = ena_q;
  assign O_sync_pulse = pulse_q;
  assign O_locked     = locked_q;
  assign O_sync_seq   = seq_q;
  assign O_lock_lost  = lost_q;

endmodule
